// File: rtl/instr_sequencer.sv
// Program-driven instruction issuer: plays a loaded program onto the core's
// instruction bus and captures result/flags after a fixed pipeline latency.
module instr_sequencer #(
  parameter  int PROG_DEPTH = 16,
  parameter  int LATENCY    = 2,
  localparam int AW         = $clog2(PROG_DEPTH),
  localparam int CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic [AW:0]   prog_len,
  output logic [7:0]    instr,
  input  logic [7:0]    result,
  input  logic          zero_flag,
  input  logic          carry_flag,
  input  logic          overflow_flag,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [2:0]    res_flags,
  output logic [AW-1:0] res_index,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  localparam logic [AW:0]   DEPTH    = (AW+1)'(PROG_DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY-1);

  logic [7:0]    r_mem [PROG_DEPTH];

  state_t        r_state, w_state;
  logic [AW-1:0] r_pc, w_pc;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [AW:0]   r_len, w_len;
  logic          r_end, w_end;
  logic [7:0]    r_instr, w_instr;
  logic          r_res_valid, w_res_valid;
  logic [7:0]    r_res_data, w_res_data;
  logic [2:0]    r_res_flags, w_res_flags;
  logic [AW-1:0] r_res_index, w_res_index;

  logic [AW:0]   w_nxt;
  logic [AW:0]   w_clamp;
  logic [7:0]    w_first;
  logic [7:0]    w_nxt_word;
  logic          w_stop;

  assign w_nxt      = {1'b0, r_pc} + 1'b1;
  assign w_clamp    = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign w_first    = r_mem[0];
  assign w_nxt_word = r_mem[w_nxt[AW-1:0]];
  assign w_stop     = (w_nxt == r_len) || (w_nxt_word[7:4] == 4'hF);

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && load_en)
      r_mem[load_addr] <= load_data;
  end

  always_comb begin
    w_state     = r_state;
    w_pc        = r_pc;
    w_cnt       = r_cnt;
    w_len       = r_len;
    w_end       = 1'b0;
    w_instr     = r_instr;
    w_res_valid = 1'b0;
    w_res_data  = r_res_data;
    w_res_flags = r_res_flags;
    w_res_index = r_res_index;
    unique case (r_state)
      S_IDLE: begin
        if (start && !load_en) begin
          w_pc  = '0;
          w_len = w_clamp;
          if (w_clamp == '0 || w_first[7:4] == 4'hF) begin
            w_state = S_FINISH;
          end else begin
            w_instr = w_first;
            w_cnt   = CNT_INIT;
            w_state = S_RUN;
          end
        end
      end
      S_RUN: begin
        // last record gets its own cycle before done is raised
        if (r_end) begin
          w_state = S_FINISH;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else begin
          w_res_valid = 1'b1;
          w_res_data  = result;
          w_res_flags = {overflow_flag, carry_flag, zero_flag};
          w_res_index = r_pc;
          if (w_stop) begin
            w_instr = 8'h00;
            w_end   = 1'b1;
          end else begin
            w_pc    = w_nxt[AW-1:0];
            w_instr = w_nxt_word;
            w_cnt   = CNT_INIT;
          end
        end
      end
      S_FINISH: w_state = S_IDLE;
      default:  w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_end       <= 1'b0;
      r_instr     <= 8'h00;
      r_res_valid <= 1'b0;
      r_res_data  <= 8'h00;
      r_res_flags <= 3'b000;
      r_res_index <= '0;
    end else begin
      r_state     <= w_state;
      r_pc        <= w_pc;
      r_cnt       <= w_cnt;
      r_len       <= w_len;
      r_end       <= w_end;
      r_instr     <= w_instr;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
      r_res_flags <= w_res_flags;
      r_res_index <= w_res_index;
    end
  end

  assign instr     = r_instr;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_flags = r_res_flags;
  assign res_index = r_res_index;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FINISH);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small core model
// (registered decode, combinational ALU; r0 = 1, r1 = 2).
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       load_en;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [4:0] prog_len;
  logic [7:0] instr;
  logic [7:0] result;
  logic       zero_flag, carry_flag, overflow_flag;
  logic       res_valid;
  logic [7:0] res_data;
  logic [2:0] res_flags;
  logic [3:0] res_index;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] exp_d [16];
  logic [2:0] exp_f [16];

  always #5 clk = ~clk;

  instr_sequencer #(.PROG_DEPTH(16), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .prog_len(prog_len), .instr(instr), .result(result),
    .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .res_valid(res_valid),
    .res_data(res_data), .res_flags(res_flags), .res_index(res_index),
    .busy(busy), .done(done)
  );

  // core model: add r0+r1 = 3, sub r0-r1 = FF {ov,c,z}=100, else 0 with zero
  logic [7:0] core_dec;
  always @(posedge clk or posedge rst) begin
    if (rst) core_dec <= 8'h00;
    else     core_dec <= instr;
  end

  always_comb begin
    result = 8'h00;
    {overflow_flag, carry_flag, zero_flag} = 3'b001;
    case (core_dec[7:4])
      4'h1: begin
        result = 8'h03;
        {overflow_flag, carry_flag, zero_flag} = 3'b000;
      end
      4'h2: begin
        result = 8'hFF;
        {overflow_flag, carry_flag, zero_flag} = 3'b100;
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [7:0] w0, w1, w2;
    logic [4:0] plen;
    logic [4:0] nrec;
    logic [7:0] forbid;
    logic [7:0] d0, d1, d2;
    logic [2:0] f0, f1, f2;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic set_exp3(input logic [7:0] d0, d1, d2,
                          input logic [2:0] f0, f1, f2);
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2;
    exp_f[0] = f0; exp_f[1] = f1; exp_f[2] = f2;
  endtask

  // e counts edges after the start edge E0; samples are 1ns after each edge
  task automatic run_check(input logic [4:0] plen, input int n,
                           input logic [7:0] forbid, input bit disturb);
    int  last;
    int  k;
    bit  v;
    last = (n == 0) ? 1 : 2*n + 2;
    @(negedge clk);
    prog_len = plen;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int e = 0; e <= last; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      chk("busy", busy, 32'(e < last));
      chk("done", done, 32'((n == 0) ? (e == 0) : (e == 2*n + 1)));
      v = (e % 2 == 0) && (e >= 2) && (e <= 2*n);
      chk("res_valid", res_valid, 32'(v));
      if (v) begin
        k = e/2 - 1;
        chk("res_index", res_index, k);
        chk("res_data", res_data, exp_d[k]);
        chk("res_flags", res_flags, exp_f[k]);
      end
      if (n == 0 || e >= 2*n)
        chk("instr_zero", instr, 0);
      if (instr === forbid)
        chk("instr_forbidden", instr, 32'hFFFF);
      if (disturb && e == 2) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_data = 8'h20;
      end
      if (disturb && e == 4) begin
        start   = 1'b0;
        load_en = 1'b0;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    load_en   = 1'b0;
    load_addr = 4'd0;
    load_data = 8'h00;
    prog_len  = 5'd0;

    vecs[0] = '{8'h10, 8'h20, 8'h00, 5'd3, 5'd3, 8'hEE,
                8'h03, 8'hFF, 8'h00, 3'b000, 3'b100, 3'b001};
    vecs[1] = '{8'h10, 8'hF0, 8'h20, 5'd3, 5'd1, 8'h20,
                8'h03, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000};
    vecs[2] = '{8'h10, 8'h20, 8'h00, 5'd0, 5'd0, 8'hEE,
                8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000};
    vecs[3] = '{8'hF5, 8'h10, 8'h10, 5'd3, 5'd0, 8'hEE,
                8'h00, 8'h00, 8'h00, 3'b000, 3'b000, 3'b000};
    vecs[4] = '{8'h20, 8'h10, 8'h00, 5'd2, 5'd2, 8'hEE,
                8'hFF, 8'h03, 8'h00, 3'b100, 3'b000, 3'b000};

    #1;
    chk("rst_instr", instr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_flags", res_flags, 0);
    chk("rst_res_index", res_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      load(4'd0, vecs[i].w0);
      load(4'd1, vecs[i].w1);
      load(4'd2, vecs[i].w2);
      set_exp3(vecs[i].d0, vecs[i].d1, vecs[i].d2,
               vecs[i].f0, vecs[i].f1, vecs[i].f2);
      run_check(vecs[i].plen, int'(vecs[i].nrec), vecs[i].forbid, 1'b0);
    end

    // asynchronous reset right after the first capture
    load(4'd0, 8'h10);
    load(4'd1, 8'h20);
    load(4'd2, 8'h00);
    set_exp3(8'h03, 8'hFF, 8'h00, 3'b000, 3'b100, 3'b001);
    @(negedge clk);
    prog_len = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", res_valid, 1);
    rst = 1'b1;
    #1;
    chk("arst_instr", instr, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_res_flags", res_flags, 0);
    chk("arst_res_index", res_index, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", {busy, res_valid}, 0);
    end
    run_check(5'd3, 3, 8'hEE, 1'b0);

    // start/load during a run are ignored
    run_check(5'd3, 3, 8'hEE, 1'b1);
    run_check(5'd3, 3, 8'hEE, 1'b0);

    // start together with load in idle: write only, no run
    @(negedge clk);
    start     = 1'b1;
    load_en   = 1'b1;
    load_addr = 4'd0;
    load_data = 8'h20;
    @(posedge clk);
    #1;
    start   = 1'b0;
    load_en = 1'b0;
    chk("start_load_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("start_load_busy2", busy, 0);
    set_exp3(8'hFF, 8'hFF, 8'h00, 3'b100, 3'b100, 3'b001);
    run_check(5'd3, 3, 8'hEE, 1'b0);

    // full memory, prog_len clamps to depth
    for (int i = 0; i < 16; i++) begin
      load(4'(i), 8'h10);
      exp_d[i] = 8'h03;
      exp_f[i] = 3'b000;
    end
    run_check(5'd31, 16, 8'hEE, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
